pipelined_control_unit: RTL and testbench

- Pipelined successor to the single-cycle opcode decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through registered ID/EX, EX/MEM and MEM/WB stages.
- Resolves branches and jumps in EX, and generates flush and load-use stall.
- Sits between instruction fetch/decode, the hazard-free datapath, the ALU (zero flag) and the PC mux.

---
 rtl/pipelined_control_unit_if.sv | 37 +++
 rtl/pipelined_control_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus between fetch/decode, the ALU and the pipelined control unit.
// master: the fetch/decode/datapath side; slave: the control unit itself.
interface pipelined_control_unit_if #(
    parameter int OP_W    = 4,
    parameter int RA_W    = 3,
    parameter int ALUOP_W = 3
);
    logic               id_valid;
    logic [OP_W-1:0]    op;
    logic [RA_W-1:0]    id_rs1;
    logic [RA_W-1:0]    id_rs2;
    logic [RA_W-1:0]    id_rd;
    logic               zero;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic               ex_alucsrc;
    logic [1:0]         PCsrc;
    logic               jal;
    logic               mem_wmem;
    logic               wb_m2reg;
    logic               wb_wreg;
    logic [RA_W-1:0]    wb_rd;
    logic               stall;
    logic               flush;
    logic               illegal;

    modport master (
        output id_valid, op, id_rs1, id_rs2, id_rd, zero,
        input  ex_ALUOp, ex_alucsrc, PCsrc, jal, mem_wmem, wb_m2reg,
               wb_wreg, wb_rd, stall, flush, illegal
    );

    modport slave (
        input  id_valid, op, id_rs1, id_rs2, id_rd, zero,
        output ex_ALUOp, ex_alucsrc, PCsrc, jal, mem_wmem, wb_m2reg,
               wb_wreg, wb_rd, stall, flush, illegal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID opcode into a control bundle, carries
// it through ID/EX, EX/MEM and MEM/WB, resolves branches/jumps in EX and raises
// flush and load-use stall.
// Optional macro CU_PERF_CNT_EN adds stall_cnt/flush_cnt/retire_cnt outputs.
module pipelined_control_unit #(
    parameter int OP_W    = 4,
    parameter int RA_W    = 3,
    parameter int ALUOP_W = 3
) (
    input  logic clk,
    input  logic rst,
    pipelined_control_unit_if.slave bus
`ifdef CU_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] retire_cnt
`endif
);

    localparam logic [3:0] OP_JAL  = 4'b0000;
    localparam logic [3:0] OP_JALR = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BLE  = 4'b0011;

    // decoded ID bundle
    logic               w_op_legal;
    logic [ALUOP_W-1:0] w_dec_aluop;
    logic               w_dec_alucsrc;
    logic               w_wreg_raw;
    logic               w_dec_wreg;
    logic               w_dec_wmem;
    logic               w_dec_m2reg;
    logic               w_dec_jal;
    logic               w_dec_jalr;
    logic               w_dec_beq;
    logic               w_dec_ble;
    logic               w_dec_use_rs1;
    logic               w_dec_use_rs2;
    logic               w_dec_illegal;

    // hazard / resolution
    logic [1:0]         w_pcsrc;
    logic               w_flush;
    logic               w_stall;
    logic               w_rs1_hit;
    logic               w_rs2_hit;
    logic               w_take;

    // ID/EX
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic               r_ex_alucsrc;
    logic               r_ex_wreg;
    logic               r_ex_wmem;
    logic               r_ex_m2reg;
    logic               r_ex_jal;
    logic               r_ex_jalr;
    logic               r_ex_beq;
    logic               r_ex_ble;
    logic [RA_W-1:0]    r_ex_rd;
    logic               r_ex_illegal;

    // EX/MEM
    logic               r_mem_wmem;
    logic               r_mem_m2reg;
    logic               r_mem_wreg;
    logic [RA_W-1:0]    r_mem_rd;

    // MEM/WB
    logic               r_wb_m2reg;
    logic               r_wb_wreg;
    logic [RA_W-1:0]    r_wb_rd;

    // Opcodes with any bit above bit 3 set are illegal.
    assign w_op_legal = ((bus.op >> 3'd4) == {OP_W{1'b0}});

    // Opcode decode into the control bundle and the source-use flags.
    always_comb begin
        w_dec_aluop   = {ALUOP_W{1'b0}};
        w_dec_alucsrc = 1'b0;
        w_wreg_raw    = 1'b0;
        w_dec_wmem    = 1'b0;
        w_dec_m2reg   = 1'b0;
        w_dec_jal     = 1'b0;
        w_dec_jalr    = 1'b0;
        w_dec_beq     = 1'b0;
        w_dec_ble     = 1'b0;
        w_dec_use_rs1 = 1'b0;
        w_dec_use_rs2 = 1'b0;
        w_dec_illegal = 1'b0;
        if (w_op_legal) begin
            case (bus.op[3:0])
                OP_JAL: begin
                    w_wreg_raw = 1'b1;
                    w_dec_jal  = 1'b1;
                end
                OP_JALR: begin
                    w_dec_alucsrc = 1'b1;
                    w_wreg_raw    = 1'b1;
                    w_dec_jalr    = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                end
                OP_BEQ: begin
                    w_dec_aluop   = ALUOP_W'(3'd4);
                    w_dec_beq     = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                    w_dec_use_rs2 = 1'b1;
                end
                OP_BLE: begin
                    w_dec_aluop   = ALUOP_W'(3'd5);
                    w_dec_ble     = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                    w_dec_use_rs2 = 1'b1;
                end
                4'b0100, 4'b0101: begin
                    w_dec_alucsrc = 1'b1;
                    w_wreg_raw    = 1'b1;
                    w_dec_m2reg   = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                end
                4'b0110, 4'b0111: begin
                    w_dec_alucsrc = 1'b1;
                    w_dec_wmem    = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                    w_dec_use_rs2 = 1'b1;
                end
                4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                    w_dec_aluop   = ALUOP_W'(bus.op[1:0]);
                    w_wreg_raw    = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                    w_dec_use_rs2 = 1'b1;
                end
                4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                    w_dec_aluop   = ALUOP_W'(bus.op[1:0]);
                    w_dec_alucsrc = 1'b1;
                    w_wreg_raw    = 1'b1;
                    w_dec_use_rs1 = 1'b1;
                end
                default: begin
                    w_dec_illegal = 1'b1;
                end
            endcase
        end else begin
            w_dec_illegal = 1'b1;
        end
        // register 0 is hardwired zero, so a write to it is suppressed
        w_dec_wreg = w_wreg_raw & (bus.id_rd != {RA_W{1'b0}});
    end

    // Branch/jump resolution on the instruction currently in EX.
    always_comb begin
        if (r_ex_jal) begin
            w_pcsrc = 2'b01;
        end else if (r_ex_jalr) begin
            w_pcsrc = 2'b10;
        end else if ((r_ex_beq | r_ex_ble) & bus.zero) begin
            w_pcsrc = 2'b01;
        end else begin
            w_pcsrc = 2'b00;
        end
    end

    assign w_flush   = (w_pcsrc != 2'b00);
    assign w_rs1_hit = w_dec_use_rs1 & (bus.id_rs1 == r_ex_rd);
    assign w_rs2_hit = w_dec_use_rs2 & (bus.id_rs2 == r_ex_rd);
    // a killed ID instruction cannot be hazarded, so flush masks stall
    assign w_stall   = ~w_flush & bus.id_valid & r_ex_m2reg &
                       (r_ex_rd != {RA_W{1'b0}}) & (w_rs1_hit | w_rs2_hit);
    assign w_take    = bus.id_valid & ~w_flush & ~w_stall;

    // ID/EX register: load the decoded bundle or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_aluop   <= {ALUOP_W{1'b0}};
            r_ex_alucsrc <= 1'b0;
            r_ex_wreg    <= 1'b0;
            r_ex_wmem    <= 1'b0;
            r_ex_m2reg   <= 1'b0;
            r_ex_jal     <= 1'b0;
            r_ex_jalr    <= 1'b0;
            r_ex_beq     <= 1'b0;
            r_ex_ble     <= 1'b0;
            r_ex_rd      <= {RA_W{1'b0}};
            r_ex_illegal <= 1'b0;
        end else if (w_take) begin
            r_ex_aluop   <= w_dec_aluop;
            r_ex_alucsrc <= w_dec_alucsrc;
            r_ex_wreg    <= w_dec_wreg;
            r_ex_wmem    <= w_dec_wmem;
            r_ex_m2reg   <= w_dec_m2reg;
            r_ex_jal     <= w_dec_jal;
            r_ex_jalr    <= w_dec_jalr;
            r_ex_beq     <= w_dec_beq;
            r_ex_ble     <= w_dec_ble;
            r_ex_rd      <= w_dec_illegal ? {RA_W{1'b0}} : bus.id_rd;
            r_ex_illegal <= w_dec_illegal;
        end else begin
            r_ex_aluop   <= {ALUOP_W{1'b0}};
            r_ex_alucsrc <= 1'b0;
            r_ex_wreg    <= 1'b0;
            r_ex_wmem    <= 1'b0;
            r_ex_m2reg   <= 1'b0;
            r_ex_jal     <= 1'b0;
            r_ex_jalr    <= 1'b0;
            r_ex_beq     <= 1'b0;
            r_ex_ble     <= 1'b0;
            r_ex_rd      <= {RA_W{1'b0}};
            r_ex_illegal <= 1'b0;
        end
    end

    // EX/MEM and MEM/WB registers: always advance, stall only bubbles ID/EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_wmem  <= 1'b0;
            r_mem_m2reg <= 1'b0;
            r_mem_wreg  <= 1'b0;
            r_mem_rd    <= {RA_W{1'b0}};
            r_wb_m2reg  <= 1'b0;
            r_wb_wreg   <= 1'b0;
            r_wb_rd     <= {RA_W{1'b0}};
        end else begin
            r_mem_wmem  <= r_ex_wmem;
            r_mem_m2reg <= r_ex_m2reg;
            r_mem_wreg  <= r_ex_wreg;
            r_mem_rd    <= r_ex_rd;
            r_wb_m2reg  <= r_mem_m2reg;
            r_wb_wreg   <= r_mem_wreg;
            r_wb_rd     <= r_mem_rd;
        end
    end

    assign bus.ex_ALUOp   = r_ex_aluop;
    assign bus.ex_alucsrc = r_ex_alucsrc;
    assign bus.PCsrc      = w_pcsrc;
    assign bus.jal        = r_ex_jal | r_ex_jalr;
    assign bus.mem_wmem   = r_mem_wmem;
    assign bus.wb_m2reg   = r_wb_m2reg;
    assign bus.wb_wreg    = r_wb_wreg;
    assign bus.wb_rd      = r_wb_rd;
    assign bus.stall      = w_stall;
    assign bus.flush      = w_flush;
    assign bus.illegal    = r_ex_illegal;

`ifdef CU_PERF_CNT_EN
    logic r_ex_valid;
    logic r_mem_valid;
    logic r_wb_valid;

    // Non-bubble marker travelling with each bundle, used for retirement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_ex_valid  <= w_take & ~w_dec_illegal;
            r_mem_valid <= r_ex_valid;
            r_wb_valid  <= r_mem_valid;
        end
    end

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= 32'd0;
            flush_cnt  <= 32'd0;
            retire_cnt <= 32'd0;
        end else begin
            stall_cnt  <= stall_cnt  + {31'd0, w_stall};
            flush_cnt  <= flush_cnt  + {31'd0, w_flush};
            retire_cnt <= retire_cnt + {31'd0, r_wb_valid};
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit (OP_W=5 so illegal opcodes exist).
// The model tracks which instruction entered EX on each cycle and derives every
// output from the opcode table; literal checks pin the documented timelines.
`timescale 1ns/1ps
module tb_pipelined_control_unit;
    localparam int OP_W = 5, RA_W = 3, ALUOP_W = 3;

    typedef struct {
        bit       valid;
        bit [4:0] op;
        bit [2:0] rs1, rs2, rd;
        bit       z;
    } instr_t;

    logic clk;
    logic rst;
    int   n_vec, n_bad;
    int   m_stall, m_flush, m_retire;
    int   pc;
    instr_t hist[$];
    instr_t prog[$];
    int   o_alu[16], o_wmem[16], o_wwreg[16], o_stall[16], o_pcsrc[16];
    int   o_flush[16], o_jal[16], o_ill[16], o_wbrd[16], o_m2r[16];

    pipelined_control_unit_if #(.OP_W(OP_W), .RA_W(RA_W), .ALUOP_W(ALUOP_W)) bus();
`ifdef CU_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;
`endif

    pipelined_control_unit #(.OP_W(OP_W), .RA_W(RA_W), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CU_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic instr_t mk(input int op, input int rs1, input int rs2, input int rd, input bit z);
        instr_t i;
        i.valid = 1'b1; i.op = op[4:0]; i.rs1 = rs1[2:0]; i.rs2 = rs2[2:0]; i.rd = rd[2:0]; i.z = z;
        return i;
    endfunction

    function automatic instr_t bub();
        instr_t i;
        i.valid = 1'b0; i.op = 5'd0; i.rs1 = 3'd0; i.rs2 = 3'd0; i.rd = 3'd0; i.z = 1'b0;
        return i;
    endfunction

    // opcode-table model
    function automatic bit legal(input instr_t i); return i.valid && i.op < 16; endfunction
    function automatic int e_aluop(input instr_t i);
        if (!legal(i)) return 0;
        if (i.op == 2) return 4;
        if (i.op == 3) return 5;
        if (i.op >= 8) return i.op % 4;
        return 0;
    endfunction
    function automatic int e_alucsrc(input instr_t i);
        return int'(legal(i) && (i.op == 1 || (i.op >= 4 && i.op <= 7) || i.op >= 12));
    endfunction
    function automatic int e_wreg(input instr_t i);
        return int'(legal(i) && (i.op <= 1 || i.op == 4 || i.op == 5 || i.op >= 8) && i.rd != 0);
    endfunction
    function automatic int e_wmem(input instr_t i);  return int'(legal(i) && (i.op == 6 || i.op == 7)); endfunction
    function automatic int e_m2reg(input instr_t i); return int'(legal(i) && (i.op == 4 || i.op == 5)); endfunction
    function automatic int e_jal(input instr_t i);   return int'(legal(i) && i.op <= 1); endfunction
    function automatic int e_ill(input instr_t i);   return int'(i.valid && i.op >= 16); endfunction
    function automatic int e_rd(input instr_t i);    return legal(i) ? int'(i.rd) : 0; endfunction
    function automatic int e_pcsrc(input instr_t i);
        if (!legal(i)) return 0;
        if (i.op == 0) return 1;
        if (i.op == 1) return 2;
        if ((i.op == 2 || i.op == 3) && i.z) return 1;
        return 0;
    endfunction
    function automatic bit use1(input instr_t i); return legal(i) && i.op != 0; endfunction
    function automatic bit use2(input instr_t i);
        return legal(i) && (i.op == 2 || i.op == 3 || i.op == 6 || i.op == 7 || (i.op >= 8 && i.op <= 11));
    endfunction
    function automatic bit e_stall(input instr_t ex, input instr_t id);
        return e_pcsrc(ex) == 0 && id.valid && e_m2reg(ex) == 1 && ex.rd != 0 &&
               ((use1(id) && id.rs1 == ex.rd) || (use2(id) && id.rs2 == ex.rd));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":ex_ALUOp"}, bus.ex_ALUOp, 0);
        chk({tag, ":ex_alucsrc"}, bus.ex_alucsrc, 0);
        chk({tag, ":PCsrc"}, bus.PCsrc, 0);
        chk({tag, ":jal"}, bus.jal, 0);
        chk({tag, ":mem_wmem"}, bus.mem_wmem, 0);
        chk({tag, ":wb_m2reg"}, bus.wb_m2reg, 0);
        chk({tag, ":wb_wreg"}, bus.wb_wreg, 0);
        chk({tag, ":wb_rd"}, bus.wb_rd, 0);
        chk({tag, ":stall"}, bus.stall, 0);
        chk({tag, ":flush"}, bus.flush, 0);
        chk({tag, ":illegal"}, bus.illegal, 0);
    endtask

    task automatic hist_reset();
        hist.delete();
        repeat (3) hist.push_back(bub());
    endtask

    // One cycle: drive ID (and zero for the EX instruction), compare at negedge, advance model.
    task automatic tick(input int k);
        instr_t id, ex, mem, wb;
        int pcs;
        bit st;
        if (pc < prog.size()) id = prog[pc]; else id = bub();
        ex  = hist[hist.size()-1];
        mem = hist[hist.size()-2];
        wb  = hist[hist.size()-3];
        bus.id_valid = id.valid;
        bus.op       = id.op;
        bus.id_rs1   = id.rs1;
        bus.id_rs2   = id.rs2;
        bus.id_rd    = id.rd;
        bus.zero     = ex.valid & ex.z;
        pcs = e_pcsrc(ex);
        st  = e_stall(ex, id);
        @(negedge clk);
        chk("ex_ALUOp", bus.ex_ALUOp, e_aluop(ex));
        chk("ex_alucsrc", bus.ex_alucsrc, e_alucsrc(ex));
        chk("PCsrc", bus.PCsrc, pcs);
        chk("jal", bus.jal, e_jal(ex));
        chk("mem_wmem", bus.mem_wmem, e_wmem(mem));
        chk("wb_m2reg", bus.wb_m2reg, e_m2reg(wb));
        chk("wb_wreg", bus.wb_wreg, e_wreg(wb));
        chk("wb_rd", bus.wb_rd, e_rd(wb));
        chk("stall", bus.stall, int'(st));
        chk("flush", bus.flush, int'(pcs != 0));
        chk("illegal", bus.illegal, e_ill(ex));
        if (k < 16) begin
            o_alu[k] = int'(bus.ex_ALUOp);  o_wmem[k] = int'(bus.mem_wmem);
            o_wwreg[k] = int'(bus.wb_wreg); o_stall[k] = int'(bus.stall);
            o_pcsrc[k] = int'(bus.PCsrc);   o_flush[k] = int'(bus.flush);
            o_jal[k] = int'(bus.jal);       o_ill[k] = int'(bus.illegal);
            o_wbrd[k] = int'(bus.wb_rd);    o_m2r[k] = int'(bus.wb_m2reg);
        end
        if (pcs == 0 && !st && id.valid) hist.push_back(id); else hist.push_back(bub());
        if (hist.size() > 4) void'(hist.pop_front());
        if (!st) pc++;
        m_stall  += int'(st);
        m_flush  += int'(pcs != 0);
        m_retire += int'(legal(wb));
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input int n);
        pc = 0;
        for (int k = 0; k < n; k++) tick(k);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; m_stall = 0; m_flush = 0; m_retire = 0;
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.op = 5'd0; bus.id_rs1 = 3'd0; bus.id_rs2 = 3'd0;
        bus.id_rd = 3'd0; bus.zero = 1'b0;
        hist_reset();
        #1;
        chk_zero("por");
        repeat (3) @(posedge clk);
        #1;
        chk_zero("por_end");
        rst = 1'b0;

        // reset mid-stream with a store and a register write in flight
        prog.delete();
        prog.push_back(mk(8, 0, 0, 1, 0));
        prog.push_back(mk(7, 1, 2, 0, 0));
        prog.push_back(mk(12, 1, 0, 2, 0));
        prog.push_back(mk(11, 1, 2, 3, 0));
        run_prog(3);
        chk("inflight_wmem", bus.mem_wmem, 1);
        chk("inflight_wreg", bus.wb_wreg, 1);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (3) begin
            @(negedge clk);
            chk_zero("rst_hold");
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        hist_reset();
        m_stall = 0; m_flush = 0; m_retire = 0;
        prog.delete();
        run_prog(2);
        chk("post_rst_PCsrc", o_pcsrc[1], 0);
        chk("post_rst_wreg", o_wwreg[1], 0);

        // stream: add r1; addi r2; sw; or r3
        prog.delete();
        prog.push_back(mk(8, 0, 0, 1, 0));
        prog.push_back(mk(12, 1, 0, 2, 0));
        prog.push_back(mk(7, 1, 2, 0, 0));
        prog.push_back(mk(11, 1, 2, 3, 0));
        run_prog(9);
        chk("stream_alu1", o_alu[1], 0);
        chk("stream_alu3", o_alu[3], 0);
        chk("stream_alu4", o_alu[4], 3);
        chk("stream_wmem3", o_wmem[3], 0);
        chk("stream_wmem4", o_wmem[4], 1);
        chk("stream_wmem5", o_wmem[5], 0);
        chk("stream_wreg3", o_wwreg[3], 1);
        chk("stream_wreg4", o_wwreg[4], 1);
        chk("stream_wreg5", o_wwreg[5], 0);
        chk("stream_wreg6", o_wwreg[6], 1);

        // load-use: lw r3; add r4,r3,r1
        prog.delete();
        prog.push_back(mk(5, 1, 0, 3, 0));
        prog.push_back(mk(8, 3, 1, 4, 0));
        run_prog(8);
        chk("lu_stall1", o_stall[1], 1);
        chk("lu_stall2", o_stall[2], 0);
        chk("lu_m2reg3", o_m2r[3], 1);
        chk("lu_wreg4", o_wwreg[4], 0);
        chk("lu_rd5", o_wbrd[5], 4);
        chk("lu_wreg5", o_wwreg[5], 1);

        // load to r0 followed by a consumer of r0: no stall
        prog.delete();
        prog.push_back(mk(5, 1, 0, 0, 0));
        prog.push_back(mk(8, 0, 1, 4, 0));
        run_prog(7);
        chk("lu0_stall1", o_stall[1], 0);
        chk("lu0_rd4", o_wbrd[4], 4);

        // branches: beq/ble taken and not taken, followed by add r5, sub r6
        for (int b = 2; b <= 3; b++) begin
            for (int zz = 0; zz <= 1; zz++) begin
                prog.delete();
                prog.push_back(mk(b, 1, 2, 0, zz[0]));
                prog.push_back(mk(8, 1, 2, 5, 0));
                prog.push_back(mk(9, 1, 2, 6, 0));
                run_prog(8);
                chk("br_alu1", o_alu[1], (b == 2) ? 4 : 5);
                chk("br_pcsrc1", o_pcsrc[1], zz);
                chk("br_flush1", o_flush[1], zz);
                chk("br_flush2", o_flush[2], 0);
                chk("br_alu3", o_alu[3], 1);
                chk("br_wreg4", o_wwreg[4], 1 - zz);
                chk("br_rd4", o_wbrd[4], (zz == 1) ? 0 : 5);
            end
        end

        // jalr preceded by a load it depends on, followed by an add it kills
        prog.delete();
        prog.push_back(mk(5, 2, 0, 1, 0));
        prog.push_back(mk(1, 1, 0, 7, 0));
        prog.push_back(mk(8, 7, 7, 1, 0));
        run_prog(9);
        chk("jalr_stall1", o_stall[1], 1);
        chk("jalr_pcsrc3", o_pcsrc[3], 2);
        chk("jalr_flush3", o_flush[3], 1);
        chk("jalr_stall3", o_stall[3], 0);
        chk("jalr_jal3", o_jal[3], 1);
        chk("jalr_wreg5", o_wwreg[5], 1);
        chk("jalr_rd5", o_wbrd[5], 7);
        chk("jalr_wreg6", o_wwreg[6], 0);

        // illegal opcode 10000 followed by add r2
        prog.delete();
        prog.push_back(mk(16, 1, 2, 1, 0));
        prog.push_back(mk(8, 1, 2, 2, 0));
        run_prog(7);
        chk("ill_pulse1", o_ill[1], 1);
        chk("ill_pulse2", o_ill[2], 0);
        chk("ill_wreg3", o_wwreg[3], 0);
        chk("ill_wmem2", o_wmem[2], 0);
        chk("ill_rd4", o_wbrd[4], 2);

`ifdef CU_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("retire_cnt", retire_cnt, m_retire);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
